// File: rtl/regfile_scoreboard_if.sv
// Bus bundle between decode/writeback and the register file scoreboard.
// The master side drives reads, issues and writebacks; the slave side answers with data and hazard status.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              read_en_1;
  logic              read_en_2;
  logic [ADDR_W-1:0] read_addr_1;
  logic [ADDR_W-1:0] read_addr_2;
  logic [DATA_W-1:0] read_data_1;
  logic [DATA_W-1:0] read_data_2;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              busy_1;
  logic              busy_2;
  logic              stall_req;
  logic              sb_error;

  modport master (
    output read_en_1, read_en_2, read_addr_1, read_addr_2,
    output issue_en, issue_addr, write_en, write_addr, write_data,
    input  read_data_1, read_data_2, busy_1, busy_2, stall_req, sb_error
  );

  modport slave (
    input  read_en_1, read_en_2, read_addr_1, read_addr_2,
    input  issue_en, issue_addr, write_en, write_addr, write_data,
    output read_data_1, read_data_2, busy_1, busy_2, stall_req, sb_error
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with a per-register pending-write counter
// that flags read hazards and latches a sticky error on counter over/underflow.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input logic                  clk,
  input logic                  rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic              sb_error_q;
  logic              sb_error_d;
  logic              wb_hit_1;
  logic              wb_hit_2;

  // Next-state: storage, pending counters and sticky error; rst folds in here.
  always_comb begin
    regs_d     = regs_q;
    cnt_d      = cnt_q;
    sb_error_d = sb_error_q;
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_d[i] = DATA_ZERO;
        cnt_d[i]  = CNT_ZERO;
      end
      sb_error_d = 1'b0;
    end else begin
      if (bus.write_en && (bus.write_addr != ADDR_ZERO)) begin
        regs_d[bus.write_addr] = bus.write_data;
      end else begin
        regs_d[0] = DATA_ZERO;
      end
      // r0 is excluded: it is never pending and never raises an error.
      for (int i = 1; i < NREG; i++) begin
        case ({bus.issue_en && (bus.issue_addr == ADDR_W'(i)),
               bus.write_en && (bus.write_addr == ADDR_W'(i))})
          2'b10: begin
            if (cnt_q[i] == CNT_MAX) begin
              sb_error_d = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
          2'b01: begin
            if (cnt_q[i] == CNT_ZERO) begin
              sb_error_d = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
          end
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    regs_q     <= regs_d;
    cnt_q      <= cnt_d;
    sb_error_q <= sb_error_d;
  end

  assign wb_hit_1 = bus.write_en && (bus.write_addr == bus.read_addr_1);
  assign wb_hit_2 = bus.write_en && (bus.write_addr == bus.read_addr_2);

  // Read ports with writeback bypass; a same-cycle writeback retires one pending write.
  always_comb begin
    bus.read_data_1 = DATA_ZERO;
    bus.busy_1      = 1'b0;
    if (!rst && bus.read_en_1 && (bus.read_addr_1 != ADDR_ZERO)) begin
      bus.read_data_1 = wb_hit_1 ? bus.write_data : regs_q[bus.read_addr_1];
      bus.busy_1      = wb_hit_1 ? (cnt_q[bus.read_addr_1] > CNT_ONE)
                                 : (cnt_q[bus.read_addr_1] != CNT_ZERO);
    end else begin
      bus.read_data_1 = DATA_ZERO;
      bus.busy_1      = 1'b0;
    end
  end

  always_comb begin
    bus.read_data_2 = DATA_ZERO;
    bus.busy_2      = 1'b0;
    if (!rst && bus.read_en_2 && (bus.read_addr_2 != ADDR_ZERO)) begin
      bus.read_data_2 = wb_hit_2 ? bus.write_data : regs_q[bus.read_addr_2];
      bus.busy_2      = wb_hit_2 ? (cnt_q[bus.read_addr_2] > CNT_ONE)
                                 : (cnt_q[bus.read_addr_2] != CNT_ZERO);
    end else begin
      bus.read_data_2 = DATA_ZERO;
      bus.busy_2      = 1'b0;
    end
  end

  assign bus.stall_req = bus.busy_1 | bus.busy_2;
  assign bus.sb_error  = sb_error_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench: each checked cycle queues its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_regfile_scoreboard;
  logic clk;
  logic rst;

  typedef struct {
    string       name;
    logic [31:0] rd1;
    logic        b1;
    logic [31:0] rd2;
    logic        b2;
    logic        st;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  bit   chk_strobe;
  int   n_checks;
  int   n_fail;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp32(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  task automatic cmp1(input string nm, input string fld, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%b required=%b", nm, fld, act, req);
    end
  endtask

  // Monitor: pops one expectation per strobed cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_strobe) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow actual=empty required=entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp32(e.name, "read_data_1", bus.read_data_1, e.rd1);
        cmp1 (e.name, "busy_1",      bus.busy_1,      e.b1);
        cmp32(e.name, "read_data_2", bus.read_data_2, e.rd2);
        cmp1 (e.name, "busy_2",      bus.busy_2,      e.b2);
        cmp1 (e.name, "stall_req",   bus.stall_req,   e.st);
        cmp1 (e.name, "sb_error",    bus.sb_error,    e.err);
      end
    end
  end

  task automatic cyc(
    input string nm, input logic r,
    input logic re1, input int ra1, input logic re2, input int ra2,
    input logic ie, input int ia,
    input logic we, input int wa, input logic [31:0] wd,
    input bit chk,
    input logic [31:0] e_rd1, input logic e_b1,
    input logic [31:0] e_rd2, input logic e_b2,
    input logic e_st, input logic e_err);
    exp_t e;
    rst             = r;
    bus.read_en_1   = re1;
    bus.read_addr_1 = 5'(ra1);
    bus.read_en_2   = re2;
    bus.read_addr_2 = 5'(ra2);
    bus.issue_en    = ie;
    bus.issue_addr  = 5'(ia);
    bus.write_en    = we;
    bus.write_addr  = 5'(wa);
    bus.write_data  = wd;
    if (chk) begin
      e.name = nm; e.rd1 = e_rd1; e.b1 = e_b1; e.rd2 = e_rd2; e.b2 = e_b2;
      e.st = e_st; e.err = e_err;
      exp_q.push_back(e);
      chk_strobe = 1'b1;
    end else begin
      chk_strobe = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_strobe = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    chk_strobe = 1'b0;
    // Initialise state with rst, then prove rst masks outputs and blocks updates.
    cyc("rst_init", 1'b1, 0,0, 0,0, 0,0, 0,0, 32'h0, 0, 32'h0,0, 32'h0,0, 0,0);
    cyc("rst_mask", 1'b1, 1,5, 1,5, 1,5, 1,5, 32'hDEADBEEF, 1, 32'h0,0, 32'h0,0, 0,0);
    cyc("reset_state", 1'b0, 1,5, 1,6, 0,0, 0,0, 32'h0, 1, 32'h0,0, 32'h0,0, 0,0);

    // Write then read back r5 with bypass.
    cyc("r5_issue",  1'b0, 1,5, 0,0, 1,5, 0,0, 32'h0, 1, 32'h0,0, 32'h0,0, 0,0);
    cyc("r5_bypass", 1'b0, 1,5, 0,0, 0,0, 1,5, 32'h1234ABCD, 1, 32'h1234ABCD,0, 32'h0,0, 0,0);
    cyc("r5_read",   1'b0, 1,5, 1,5, 0,0, 0,0, 32'h0, 1, 32'h1234ABCD,0, 32'h1234ABCD,0, 0,0);

    // r0 is hardwired zero and never pending.
    cyc("r0_write", 1'b0, 1,0, 1,0, 1,0, 1,0, 32'hFFFFFFFF, 1, 32'h0,0, 32'h0,0, 0,0);
    cyc("r0_read",  1'b0, 1,0, 1,0, 0,0, 0,0, 32'h0, 1, 32'h0,0, 32'h0,0, 0,0);

    // Single pending write on r3.
    cyc("r3_issue", 1'b0, 0,0, 1,3, 1,3, 0,0, 32'h0, 1, 32'h0,0, 32'h0,0, 0,0);
    cyc("r3_busy",  1'b0, 1,3, 0,0, 0,0, 0,0, 32'h0, 1, 32'h0,1, 32'h0,0, 1,0);
    cyc("r3_wb",    1'b0, 1,3, 0,0, 0,0, 1,3, 32'h55, 1, 32'h55,0, 32'h0,0, 0,0);
    cyc("r3_after", 1'b0, 1,3, 0,3, 0,0, 0,0, 32'h0, 1, 32'h55,0, 32'h0,0, 0,0);

    // Two pending writes on r7; plus independent issue to r8.
    cyc("r7_iss1", 1'b0, 1,7, 0,0, 1,7, 0,0, 32'h0, 1, 32'h0,0, 32'h0,0, 0,0);
    cyc("r7_iss2", 1'b0, 1,7, 0,0, 1,7, 0,0, 32'h0, 1, 32'h0,1, 32'h0,0, 1,0);
    cyc("r7_wb1",  1'b0, 1,7, 0,0, 0,0, 1,7, 32'hA1, 1, 32'hA1,1, 32'h0,0, 1,0);
    cyc("r7_mid",  1'b0, 1,7, 0,0, 0,0, 0,0, 32'h0, 1, 32'hA1,1, 32'h0,0, 1,0);
    cyc("r7_wb2",  1'b0, 1,7, 1,8, 1,8, 1,7, 32'hA2, 1, 32'hA2,0, 32'h0,0, 0,0);
    cyc("r7_done", 1'b0, 1,7, 1,8, 0,0, 0,0, 32'h0, 1, 32'hA2,0, 32'h0,1, 1,0);
    cyc("r8_both", 1'b0, 0,0, 1,8, 1,8, 1,8, 32'h88, 1, 32'h0,0, 32'h88,0, 0,0);
    cyc("r8_still",1'b0, 0,0, 1,8, 0,0, 0,0, 32'h0, 1, 32'h0,0, 32'h88,1, 1,0);
    cyc("r8_wb",   1'b0, 0,0, 1,8, 0,0, 1,8, 32'h89, 1, 32'h0,0, 32'h89,0, 0,0);

    // Saturate r9 (CNT_MAX=3) then drain three times.
    cyc("r9_iss1", 1'b0, 1,9, 0,0, 1,9, 0,0, 32'h0, 1, 32'h0,0, 32'h0,0, 0,0);
    cyc("r9_iss2", 1'b0, 1,9, 0,0, 1,9, 0,0, 32'h0, 1, 32'h0,1, 32'h0,0, 1,0);
    cyc("r9_iss3", 1'b0, 1,9, 0,0, 1,9, 0,0, 32'h0, 1, 32'h0,1, 32'h0,0, 1,0);
    cyc("r9_iss4", 1'b0, 1,9, 0,0, 1,9, 0,0, 32'h0, 1, 32'h0,1, 32'h0,0, 1,0);
    cyc("r9_err",  1'b0, 1,9, 0,0, 0,0, 0,0, 32'h0, 1, 32'h0,1, 32'h0,0, 1,1);
    cyc("r9_wb1",  1'b0, 1,9, 0,0, 0,0, 1,9, 32'h91, 1, 32'h91,1, 32'h0,0, 1,1);
    cyc("r9_wb2",  1'b0, 1,9, 0,0, 0,0, 1,9, 32'h92, 1, 32'h92,1, 32'h0,0, 1,1);
    cyc("r9_wb3",  1'b0, 1,9, 0,0, 0,0, 1,9, 32'h93, 1, 32'h93,0, 32'h0,0, 0,1);
    cyc("r10_wb0", 1'b0, 1,9, 0,0, 0,0, 1,10, 32'hBEEF, 1, 32'h93,0, 32'h0,0, 0,1);
    cyc("r10_rd",  1'b0, 1,10, 0,0, 0,0, 0,0, 32'h0, 1, 32'hBEEF,0, 32'h0,0, 0,1);

    // Reset discards pending r4, all data and the sticky error.
    cyc("r4_issue", 1'b0, 1,4, 0,0, 1,4, 0,0, 32'h0, 1, 32'h0,0, 32'h0,0, 0,1);
    cyc("r4_rst",   1'b1, 1,4, 1,5, 1,4, 1,4, 32'h44, 1, 32'h0,0, 32'h0,0, 0,1);
    cyc("r4_after", 1'b0, 1,4, 1,5, 0,0, 0,0, 32'h0, 1, 32'h0,0, 32'h0,0, 0,0);

    cyc("drain", 1'b0, 0,0, 0,0, 0,0, 0,0, 32'h0, 0, 32'h0,0, 32'h0,0, 0,0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width; register count is 2^ADDR_W.
REQ-003 Parameter CNT_W, default 2, width of each per-register pending-write counter; CNT_MAX = 2^CNT_W-1.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 read_en_1 / read_en_2  in  1  read-port enables from decode.
REQ-007 read_addr_1 / read_addr_2  in  ADDR_W  read-port register addresses.
REQ-008 read_data_1 / read_data_2  out  DATA_W  read-port data, combinational.
REQ-009 issue_en  in  1  decode has issued an instruction that will write issue_addr.
REQ-010 issue_addr  in  ADDR_W  destination register of the issued instruction.
REQ-011 write_en  in  1  writeback write enable.
REQ-012 write_addr  in  ADDR_W  writeback destination register.
REQ-013 write_data  in  DATA_W  writeback data.
REQ-014 busy_1 / busy_2  out  1  read port n targets a register with an unresolved pending write, combinational.
REQ-015 stall_req  out  1  busy_1 OR busy_2.
REQ-016 sb_error  out  1  sticky scoreboard error flag, registered.

Function
REQ-017 Register 0 SHALL read as 0, SHALL never be written, and SHALL never be counted as pending.
REQ-018 Writes SHALL update storage at the rising edge when write_en=1 and write_addr!=0.
REQ-019 read_data_n SHALL be 0 when read_en_n=0 or read_addr_n=0.
REQ-020 read_data_n SHALL equal write_data in the same cycle when write_en=1 and write_addr=read_addr_n!=0 (write-to-read bypass); otherwise it SHALL equal the stored value.
REQ-021 Each register SHALL have a pending counter: +1 on a cycle with issue_en=1 to it, -1 on a cycle with write_en=1 to it, unchanged when both occur to it in the same cycle.
REQ-022 An issue to a register whose counter equals CNT_MAX (and no simultaneous writeback to it) SHALL leave the counter at CNT_MAX and set sb_error.
REQ-023 A writeback to a register whose counter equals 0 (and no simultaneous issue to it) SHALL still write data, leave the counter at 0, and set sb_error.
REQ-024 busy_n SHALL be 1 iff read_en_n=1, read_addr_n!=0, and the counter for read_addr_n exceeds 1 when a same-cycle writeback to read_addr_n occurs, or exceeds 0 otherwise.
REQ-025 Issue and writeback to different registers in the same cycle SHALL update both counters independently.
REQ-026 sb_error SHALL remain 1 once set until rst.
REQ-027 Counter and error updates SHALL take effect at the rising edge; busy_n SHALL reflect the updated counter from the next cycle.

Reset
REQ-028 While rst=1 at a rising edge, all registers SHALL be cleared to 0, all counters cleared to 0, and sb_error cleared to 0; issue_en and write_en SHALL be ignored in that cycle.
REQ-029 While rst=1, read_data_1, read_data_2, busy_1, busy_2 and stall_req SHALL be 0 regardless of other inputs.
REQ-030 Asserting rst with pending counters non-zero SHALL discard all pending state; no writeback or issue takes effect until the first edge with rst=0.

Verification
REQ-031 Write r5=0x1234ABCD, next cycle read port 1 r5 -> read_data_1=0x1234ABCD, busy_1=0.
REQ-032 write_en=1 to r0 with 0xFFFFFFFF, read r0 on both ports -> read_data=0, busy=0, sb_error=0.
REQ-033 Issue r3; next cycle read r3 -> busy_1=1, stall_req=1; writeback r3=0x55 while reading r3 -> read_data_1=0x55, busy_1=0 same cycle.
REQ-034 Issue r7 twice in consecutive cycles, writeback r7 once while reading r7 -> busy stays 1; second writeback -> busy 0.
REQ-035 Issue r9 four times (CNT_W=2) -> counter stays 3, sb_error=1; writeback to r10 with counter 0 -> sb_error stays 1, data written.
REQ-036 Issue r4, assert rst one cycle, release, read r4 -> busy_1=0, read_data_1=0, sb_error=0.
